lcd_char_writer: RTL and testbench

//  Downstream consumer of the operator-symbol byte stream (8-bit LCD char codes, e.g. 0x2B '+', 0x3D '=').

---
 rtl/lcd_char_writer_if.sv | 23 ++
 rtl/lcd_char_writer.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_char_writer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_char_writer_if.sv
// Character handshake between the operator-symbol source and the LCD writer.
// The source (master) presents a character code with a valid flag, or asks
// for a clear; the writer (slave) answers with a combinational ready.
interface lcd_char_writer_if;
   logic [7:0] i_char;
   logic       i_valid;
   logic       i_clear;
   logic       o_ready;

   modport master (
      output i_char,
      output i_valid,
      output i_clear,
      input  o_ready
   );

   modport slave (
      input  i_char,
      input  i_valid,
      input  i_clear,
      output o_ready
   );
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780-compatible character LCD writer, 8-bit write-only mode.
// After reset it waits for the panel to power up, runs the four-command init
// sequence, then writes each accepted character at the cursor. It issues a
// DDRAM set-address command whenever the cursor wraps onto a line start.
// Optional feature macro: LCD_TWO_LINE_EN selects the two-line panel
// (function set 0x38, cursor 0..31). Without it the panel is single-line
// (function set 0x30, cursor 0..15).
module lcd_char_writer #(
   parameter int unsigned PWR_WAIT_CYC = 750000,
   parameter int unsigned E_PULSE_CYC  = 25,
   parameter int unsigned CMD_WAIT_CYC = 2000,
   parameter int unsigned CLR_WAIT_CYC = 82000
) (
   input  logic                clk,
   input  logic                rst,
   lcd_char_writer_if.slave    bus,
   output logic                o_lcd_e,
   output logic                o_lcd_rs,
   output logic                o_lcd_rw,
   output logic [7:0]          o_lcd_data,
   output logic [4:0]          o_cursor
);

   // Every LCD access, whether an init command, a character, a set-address
   // or a clear, goes through the same SETUP -> E_HIGH -> WAIT cycle. The
   // kind register remembers what the write was for, so that the end of WAIT
   // knows where to go next.
   typedef enum logic [2:0] {
      S_PWR_WAIT,
      S_SETUP,
      S_E_HIGH,
      S_WAIT,
      S_IDLE
   } state_t;

   typedef enum logic [1:0] {
      K_INIT,
      K_CHAR,
      K_ADDR,
      K_CLEAR
   } kind_t;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_LINE0 = 8'h80;

`ifdef LCD_TWO_LINE_EN
   localparam logic [7:0] FUNC_SET  = 8'h38;
   localparam logic [7:0] CMD_LINE1 = 8'hC0;
`else
   localparam logic [7:0] FUNC_SET  = 8'h30;
`endif

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  initIdx_q, initIdx_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic [4:0]  cursor_q, cursor_d;

   logic [31:0] waitLen;
   logic [4:0]  nextCursor;
   logic        lineStart;
   logic [7:0]  lineAddr;

   // Power-up command list, indexed by position in the init sequence.
   function automatic logic [7:0] initCmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = FUNC_SET;
         2'd1:    cmd = 8'h0C;
         2'd2:    cmd = CMD_CLEAR;
         default: cmd = 8'h06;
      endcase
      return cmd;
   endfunction

   // Only the clear instruction needs the long settle time; a data byte of
   // 0x01 is an ordinary character write.
   assign waitLen = (!rs_q && (data_q == CMD_CLEAR)) ? 32'(CLR_WAIT_CYC)
                                                     : 32'(CMD_WAIT_CYC);

`ifdef LCD_TWO_LINE_EN
   assign nextCursor = cursor_q + 5'd1;
   assign lineStart  = (nextCursor == 5'd16) || (nextCursor == 5'd0);
   assign lineAddr   = (nextCursor == 5'd16) ? CMD_LINE1 : CMD_LINE0;
`else
   assign nextCursor = {1'b0, cursor_q[3:0] + 4'd1};
   assign lineStart  = (nextCursor[3:0] == 4'd0);
   assign lineAddr   = CMD_LINE0;
`endif

   // State and datapath registers; reset drops the strobe at once and
   // restarts the whole power-up sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_PWR_WAIT;
         kind_q    <= K_INIT;
         cnt_q     <= '0;
         initIdx_q <= '0;
         rs_q      <= 1'b0;
         data_q    <= 8'h00;
         cursor_q  <= 5'd0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         cnt_q     <= cnt_d;
         initIdx_q <= initIdx_d;
         rs_q      <= rs_d;
         data_q    <= data_d;
         cursor_q  <= cursor_d;
      end
   end

   // Sequencer: the power-up wait, the write cycle timing, and the choice of
   // the next write (next init command, line-start address, or back to idle).
   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      cnt_d     = cnt_q;
      initIdx_d = initIdx_q;
      rs_d      = rs_q;
      data_d    = data_q;
      cursor_d  = cursor_q;

      case (state_q)
         S_PWR_WAIT: begin
            if (cnt_q == PWR_WAIT_CYC - 1) begin
               state_d   = S_SETUP;
               cnt_d     = '0;
               kind_d    = K_INIT;
               initIdx_d = 2'd0;
               rs_d      = 1'b0;
               data_d    = initCmd(2'd0);
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         S_SETUP: begin
            state_d = S_E_HIGH;
            cnt_d   = '0;
         end

         S_E_HIGH: begin
            if (cnt_q == E_PULSE_CYC - 1) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         S_WAIT: begin
            if (cnt_q == waitLen - 32'd1) begin
               cnt_d = '0;
               case (kind_q)
                  K_INIT: begin
                     if (initIdx_q == 2'd3) begin
                        state_d = S_IDLE;
                     end else begin
                        state_d   = S_SETUP;
                        initIdx_d = initIdx_q + 2'd1;
                        data_d    = initCmd(initIdx_q + 2'd1);
                     end
                  end
                  K_CHAR: begin
                     cursor_d = nextCursor;
                     if (lineStart) begin
                        state_d = S_SETUP;
                        kind_d  = K_ADDR;
                        rs_d    = 1'b0;
                        data_d  = lineAddr;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end
                  default: begin
                     state_d = S_IDLE;
                  end
               endcase
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         S_IDLE: begin
            if (bus.i_clear) begin
               state_d  = S_SETUP;
               kind_d   = K_CLEAR;
               rs_d     = 1'b0;
               data_d   = CMD_CLEAR;
               cursor_d = 5'd0;
               cnt_d    = '0;
            end else if (bus.i_valid) begin
               state_d = S_SETUP;
               kind_d  = K_CHAR;
               rs_d    = 1'b1;
               data_d  = bus.i_char;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = S_PWR_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.o_ready = (state_q == S_IDLE) && !bus.i_clear;
   assign o_lcd_e     = (state_q == S_E_HIGH);
   assign o_lcd_rs    = rs_q;
   assign o_lcd_rw    = 1'b0;
   assign o_lcd_data  = data_q;
   assign o_cursor    = cursor_q;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Self-checking bench for lcd_char_writer with short timing parameters.
// A reference model keeps the list of LCD writes each request must produce
// and the cursor position; a monitor matches every E pulse against it.
module tb_lcd_char_writer;

   localparam int PWR   = 10;
   localparam int EP    = 2;
   localparam int CMDW  = 4;
   localparam int CLRW  = 8;
   localparam int BOUND = 200;

`ifdef LCD_TWO_LINE_EN
   localparam int         NUM_CELLS = 32;
   localparam logic [7:0] FUNC      = 8'h38;
`else
   localparam int         NUM_CELLS = 16;
   localparam logic [7:0] FUNC      = 8'h30;
`endif
   localparam int LINE_LEN = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lcdE, lcdRs, lcdRw;
   logic [7:0] lcdData;
   logic [4:0] cursor;

   lcd_char_writer_if bus();

   lcd_char_writer #(
      .PWR_WAIT_CYC(PWR),
      .E_PULSE_CYC (EP),
      .CMD_WAIT_CYC(CMDW),
      .CLR_WAIT_CYC(CLRW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .o_lcd_e   (lcdE),
      .o_lcd_rs  (lcdRs),
      .o_lcd_rw  (lcdRw),
      .o_lcd_data(lcdData),
      .o_cursor  (cursor)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         gap;
   } wr_t;

   wr_t expQ[$];
   int  checks      = 0;
   int  failures    = 0;
   int  mCursor     = 0;
   int  readyAt     = -1;
   int  sinceAccept = 0;

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic int writeLen(input logic rsv, input logic [7:0] d);
      return 1 + EP + ((!rsv && d == 8'h01) ? CLRW : CMDW);
   endfunction

   task automatic pushWrite(input logic rsv, input logic [7:0] d, input int gap);
      wr_t w;
      w.rs   = rsv;
      w.data = d;
      w.gap  = gap;
      expQ.push_back(w);
   endtask

   // Model of the power-up sequence that follows a reset release.
   task automatic modelInit();
      expQ.delete();
      mCursor = 0;
      pushWrite(1'b0, FUNC,  PWR);
      pushWrite(1'b0, 8'h0C, 1 + CMDW);
      pushWrite(1'b0, 8'h01, 1 + CMDW);
      pushWrite(1'b0, 8'h06, 1 + CLRW);
      readyAt = PWR + writeLen(1'b0, FUNC) + writeLen(1'b0, 8'h0C)
              + writeLen(1'b0, 8'h01) + writeLen(1'b0, 8'h06);
      sinceAccept = 0;
   endtask

   // Model of one accepted character: the data write, then a set-address
   // write if the cursor lands on the start of a line.
   task automatic modelChar(input logic [7:0] c);
      int busy;
      logic [7:0] addr;
      pushWrite(1'b1, c, -1);
      busy    = writeLen(1'b1, c);
      mCursor = (mCursor + 1) % NUM_CELLS;
      if (mCursor % LINE_LEN == 0) begin
         addr = (mCursor == 0) ? 8'h80 : 8'hC0;
         pushWrite(1'b0, addr, 1 + CMDW);
         busy += writeLen(1'b0, addr);
      end
      readyAt     = busy + 1;
      sinceAccept = 0;
   endtask

   task automatic modelClear();
      pushWrite(1'b0, 8'h01, -1);
      mCursor     = 0;
      readyAt     = writeLen(1'b0, 8'h01) + 1;
      sinceAccept = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      sinceAccept++;
   endtask

   // Wait for o_ready, checking how long the previous request kept it low
   // and where the cursor ended up.
   task automatic waitIdle();
      int n;
      n = 0;
      while (!bus.o_ready && n < BOUND) begin
         tick();
         n++;
      end
      if (!bus.o_ready) begin
         checkOutput("idleTimeout", bus.o_ready, 1);
      end else begin
         if (readyAt >= 0) begin
            checkOutput("busyLen", sinceAccept, readyAt);
            readyAt = -1;
         end
         checkOutput("cursor", cursor, mCursor);
      end
   endtask

   task automatic sendChar(input logic [7:0] c, input bit hold);
      bus.i_char  = c;
      bus.i_valid = 1'b1;
      #1;
      waitIdle();
      modelChar(c);
      tick();
      checkOutput("setupRs", lcdRs, 1);
      checkOutput("setupData", lcdData, c);
      checkOutput("setupE", lcdE, 0);
      checkOutput("busyReady", bus.o_ready, 0);
      if (!hold) bus.i_valid = 1'b0;
      tick();
      checkOutput("eRise", lcdE, 1);
      if (!hold) waitIdle();
   endtask

   task automatic sendClear(input bit withChar, input logic [7:0] c);
      bus.i_valid = 1'b0;
      #1;
      waitIdle();
      bus.i_clear = 1'b1;
      if (withChar) begin
         bus.i_char  = c;
         bus.i_valid = 1'b1;
      end
      #1;
      checkOutput("clrReady", bus.o_ready, 0);
      modelClear();
      tick();
      bus.i_clear = 1'b0;
      checkOutput("clrRs", lcdRs, 0);
      checkOutput("clrData", lcdData, 8'h01);
      if (withChar) sendChar(c, 1'b0);
      else waitIdle();
   endtask

   // One operation from the stimulus mix: a character (optionally held
   // valid for a back-to-back follow-up) or a clear.
   task automatic applyStimulus(input bit isClear, input logic [7:0] c, input bit flag);
      if (isClear) sendClear(flag, c);
      else sendChar(c, flag);
   endtask

   // Reset arrives while a character's enable pulse is high.
   task automatic resetMidWrite(input logic [7:0] c);
      bus.i_char  = c;
      bus.i_valid = 1'b1;
      #1;
      waitIdle();
      modelChar(c);
      tick();
      bus.i_valid = 1'b0;
      tick();
      checkOutput("abortERise", lcdE, 1);
      rst = 1'b1;
      #1;
      checkOutput("abortE", lcdE, 0);
      checkOutput("abortData", lcdData, 8'h00);
      checkOutput("abortRs", lcdRs, 0);
      checkOutput("abortCursor", cursor, 0);
      tick();
      tick();
      rst = 1'b0;
      modelInit();
      waitIdle();
   endtask

   // Monitor: every rising E must match the next expected write, and the
   // pulse width, the bus hold and the idle gap before it are checked.
   int         lowCnt  = 0;
   int         highCnt = 0;
   logic       prevE   = 1'b0;
   logic [7:0] curData = 8'h00;
   logic       curRs   = 1'b0;

   always @(negedge clk) begin
      wr_t w;
      if (rst) begin
         prevE   = 1'b0;
         lowCnt  = 0;
         highCnt = 0;
      end else begin
         if (lcdE && !prevE) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedWrite", lcdData, 9'h100);
            end else begin
               w = expQ.pop_front();
               checkOutput("wrRs", lcdRs, w.rs);
               checkOutput("wrData", lcdData, w.data);
               checkOutput("wrRw", lcdRw, 0);
               if (w.gap >= 0) checkOutput("wrGap", lowCnt, w.gap);
            end
            curData = lcdData;
            curRs   = lcdRs;
            highCnt = 1;
         end else if (lcdE) begin
            highCnt++;
         end else if (prevE) begin
            checkOutput("eWidth", highCnt, EP);
            checkOutput("holdData", lcdData, curData);
            checkOutput("holdRs", lcdRs, curRs);
            lowCnt = 1;
         end else begin
            lowCnt++;
         end
         prevE = lcdE;
      end
   end

   initial begin
      logic [7:0] c;
      int         r;
      bus.i_char  = 8'h00;
      bus.i_valid = 1'b0;
      bus.i_clear = 1'b0;
      rst         = 1'b1;
      tick();
      checkOutput("rstE", lcdE, 0);
      checkOutput("rstRs", lcdRs, 0);
      checkOutput("rstRw", lcdRw, 0);
      checkOutput("rstData", lcdData, 8'h00);
      checkOutput("rstCursor", cursor, 0);
      checkOutput("rstReady", bus.o_ready, 0);
      tick();
      rst = 1'b0;
      modelInit();
      waitIdle();

      applyStimulus(1'b0, 8'h2B, 1'b0);

      applyStimulus(1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h3D, 1'b0);

      applyStimulus(1'b1, 8'h21, 1'b1);

      applyStimulus(1'b0, 8'h2D, 1'b1);
      applyStimulus(1'b0, 8'h2F, 1'b0);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         case ($urandom_range(0, 5))
            0:       c = 8'h20;
            1:       c = 8'hD7;
            2:       c = 8'hF7;
            3:       c = 8'h01;
            default: c = 8'($urandom_range(0, 255));
         endcase
         if (r == 0) applyStimulus(1'b1, c, 1'($urandom_range(0, 1)));
         else applyStimulus(1'b0, c, 1'($urandom_range(0, 1)));
      end

      resetMidWrite(8'h41);
      applyStimulus(1'b0, 8'h42, 1'b0);

      repeat (4) tick();
      checkOutput("queueDrained", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
